pwm_mod: RTL

Converts the signed sample stream produced by the DDS stage into a fixed-period, center-free (edge-aligned) PWM waveform with complementary high/low-side drive outputs. It sits directly downstream of the DDS in the PWM_DDS path, shares its clock and clock enable, and latches one new sample per PWM period. Optional dead-time insertion protects an external half-bridge.

---
 rtl/pwm_mod.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pwm_mod.sv
// pwm_mod: edge-aligned PWM from the signed DDS sample stream, complementary hi/lo drive.
// Define PWM_DEADTIME_EN to compile in the dead-time FSM; otherwise DeadTime is ignored.
`timescale 1ns/1ps
module pwm_mod #(
  parameter int DATA_W = 12,
  parameter int DEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ClkEn,
  input  logic              Enable,
  input  logic [DATA_W-1:0] Sample,
  input  logic [DEAD_W-1:0] DeadTime,
  output logic              PwmHi,
  output logic              PwmLo,
  output logic              PeriodStart
);

  // Period is 2^DATA_W - 1 counts, so the last count value is 2^DATA_W - 2.
  localparam logic [DATA_W-1:0] CNT_LAST = {{(DATA_W-1){1'b1}}, 1'b0};
  localparam logic [DATA_W-1:0] CNT_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] duty_reg;
  logic [DATA_W-1:0] duty_in;
  logic              first_pend;
  logic              wrap;
  logic              advance;
  logic              raw;

  assign duty_in = {~Sample[DATA_W-1], Sample[DATA_W-2:0]};
  assign advance = ClkEn & Enable;
  // first_pend makes the first enabled edge behave like a wrap: latch and pulse, cnt stays 0.
  assign wrap    = (cnt == CNT_LAST) | first_pend;
  assign raw     = (cnt < duty_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      duty_reg    <= '0;
      first_pend  <= 1'b1;
      PeriodStart <= 1'b0;
    end else begin
      PeriodStart <= advance & wrap;
      if (!Enable) begin
        cnt        <= '0;
        duty_reg   <= duty_in;
        first_pend <= 1'b1;
      end else if (ClkEn) begin
        if (wrap) begin
          cnt        <= '0;
          duty_reg   <= duty_in;
          first_pend <= 1'b0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  // state     | meaning
  // S_OFF     | disabled, both outputs low
  // S_LO_ON   | low side driven
  // S_DEAD_UP | both low, waiting to turn the high side on
  // S_HI_ON   | high side driven
  // S_DEAD_DN | both low, waiting to turn the low side on
  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_LO_ON   = 3'd1,
    S_DEAD_UP = 3'd2,
    S_HI_ON   = 3'd3,
    S_DEAD_DN = 3'd4
  } state_t;

  localparam logic [DEAD_W-1:0] DEAD_ONE = {{(DEAD_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [DEAD_W-1:0] dead_cnt;
  logic [DEAD_W-1:0] dead_cnt_nx;
  logic              dead_zero;

  assign dead_zero = (DeadTime == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_OFF;
      dead_cnt <= '0;
      PwmHi    <= 1'b0;
      PwmLo    <= 1'b0;
    end else begin
      state    <= state_nx;
      dead_cnt <= dead_cnt_nx;
      PwmHi    <= (state_nx == S_HI_ON);
      PwmLo    <= (state_nx == S_LO_ON);
    end
  end

  // Dead counter is loaded with DeadTime-1 so the both-low window lasts exactly DeadTime clks.
  always_comb begin
    state_nx    = state;
    dead_cnt_nx = dead_cnt;
    if (!Enable) begin
      state_nx    = S_OFF;
      dead_cnt_nx = '0;
    end else begin
      case (state)
        S_OFF, S_LO_ON: begin
          if (raw) begin
            if (dead_zero) begin
              state_nx = S_HI_ON;
            end else begin
              state_nx    = S_DEAD_UP;
              dead_cnt_nx = DeadTime - DEAD_ONE;
            end
          end else begin
            state_nx = S_LO_ON;
          end
        end
        S_DEAD_UP: begin
          if (!raw) begin
            state_nx    = S_LO_ON;
            dead_cnt_nx = '0;
          end else if (dead_cnt == '0) begin
            state_nx = S_HI_ON;
          end else begin
            dead_cnt_nx = dead_cnt - DEAD_ONE;
          end
        end
        S_HI_ON: begin
          if (!raw) begin
            if (dead_zero) begin
              state_nx = S_LO_ON;
            end else begin
              state_nx    = S_DEAD_DN;
              dead_cnt_nx = DeadTime - DEAD_ONE;
            end
          end
        end
        S_DEAD_DN: begin
          if (raw) begin
            state_nx    = S_HI_ON;
            dead_cnt_nx = '0;
          end else if (dead_cnt == '0) begin
            state_nx = S_LO_ON;
          end else begin
            dead_cnt_nx = dead_cnt - DEAD_ONE;
          end
        end
        default: begin
          state_nx    = S_OFF;
          dead_cnt_nx = '0;
        end
      endcase
    end
  end
`else
  logic unused_dead;
  assign unused_dead = ^DeadTime;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PwmHi <= 1'b0;
      PwmLo <= 1'b0;
    end else begin
      PwmHi <= Enable & raw;
      PwmLo <= Enable & ~raw;
    end
  end
`endif

endmodule
